// File: rtl/if_fetch_port_if.sv
// Fetch-port bundle: PC-register side, ctrl side, IF/ID side and the
// instruction memory bus, all seen from the fetch responder (slave).
//
// Memory bus handshake: bus_req_o/bus_addr_o form the request, bus_ack_i the
// response. A read completes in the cycle where bus_req_o=1 and bus_ack_i=1,
// and bus_rdata_i is valid only in that cycle. Once bus_req_o rises it stays
// high with bus_addr_o unchanged until that completing cycle. bus_ack_i has no
// meaning while bus_req_o=0.
interface if_fetch_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ce_i;
    logic [ADDR_W-1:0] pc_i;
    logic [5:0]        stall_i;
    logic              flush_i;
    logic              stallreq_o;
    logic [DATA_W-1:0] inst_o;
    logic              inst_valid_o;
    logic              adel_o;
    logic              bus_req_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport slave (
        input  ce_i, pc_i, stall_i, flush_i, bus_ack_i, bus_rdata_i,
        output stallreq_o, inst_o, inst_valid_o, adel_o, bus_req_o, bus_addr_o
    );

    modport master (
        output ce_i, pc_i, stall_i, flush_i, bus_ack_i, bus_rdata_i,
        input  stallreq_o, inst_o, inst_valid_o, adel_o, bus_req_o, bus_addr_o
    );
endinterface

// File: rtl/if_fetch_port.sv
// Instruction fetch responder: turns each PC from the PC register into one
// req/ack read on the instruction memory bus, holds the pipeline with
// stallreq_o until the word is ready, absorbs flushes (draining a request
// that cannot be withdrawn) and flags misaligned PCs without touching the bus.
module if_fetch_port #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_port_if.slave fp,
    output logic [1:0] state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] inst_buf_q, inst_buf_d;
    logic              adel_q, adel_d;
    logic              stallreq;

    // Only the PC-hold bit of the stall vector matters to fetch.
    logic unused_stall_bits;
    assign unused_stall_bits = ^fp.stall_i[5:1];

    // State and bus registers; reset drops any outstanding request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            inst_buf_q <= NOP_INST;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            inst_buf_q <= inst_buf_d;
            adel_q     <= adel_d;
        end
    end

    // Next-state, bus request and stall-request decode.
    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        inst_buf_d = inst_buf_q;
        adel_d     = adel_q;
        stallreq   = 1'b0;
        case (state_q)
            IDLE: begin
                stallreq = fp.ce_i & ~fp.flush_i;
                if (fp.ce_i && !fp.flush_i) begin
                    if (fp.pc_i[1:0] == 2'b00) begin
                        bus_addr_d = fp.pc_i;
                        bus_req_d  = 1'b1;
                        state_d    = BUSY;
                    end else begin
                        // Misaligned PC: report the error instead of reading.
                        inst_buf_d = NOP_INST;
                        adel_d     = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            BUSY: begin
                stallreq = 1'b1;
                if (fp.bus_ack_i) begin
                    bus_req_d = 1'b0;
                    if (!fp.flush_i) begin
                        inst_buf_d = fp.bus_rdata_i;
                        adel_d     = 1'b0;
                        state_d    = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fp.flush_i) begin
                    // The request is already on the bus; drain it in ABORT.
                    state_d = ABORT;
                end
            end
            ABORT: begin
                stallreq = 1'b1;
                if (fp.bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                if (fp.flush_i || !fp.stall_i[0]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fp.stallreq_o   = stallreq;
    assign fp.bus_req_o    = bus_req_q;
    assign fp.bus_addr_o   = bus_addr_q;
    assign fp.inst_valid_o = (state_q == DONE);
    assign fp.inst_o       = (state_q == DONE) ? inst_buf_q : NOP_INST;
    assign fp.adel_o       = (state_q == DONE) ? adel_q : 1'b0;
    assign state_dbg_o     = state_q;

endmodule

// File: doc/if_fetch_port.md
Name: if_fetch_port

Overview:
Responder side of the PC-register fetch interface. It accepts the instruction address (pc_i) and chip-enable (ce_i) driven by the PC register and turns each address into one read on the instruction memory bus, which uses a req/ack handshake. It returns the fetched word to the IF/ID stage and requests a pipeline stall until the word is available. It also absorbs flushes and detects misaligned PCs.

Parameters:
ADDR_W, 32, width of PC and bus address
DATA_W, 32, instruction word width
NOP_INST, 32'h0000_0000, word presented to IF/ID when no valid instruction is available

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
ce_i  input  1  fetch enable from PC register; 0 means the PC is still in reset
pc_i  input  ADDR_W  current PC from PC register
stall_i  input  6  pipeline stall vector from ctrl; bit0 set means the PC holds
flush_i  input  1  pipeline flush; PC loads new_pc at the same edge
stallreq_o  output  1  stall request to ctrl; fetch for pc_i is not complete
inst_o  output  DATA_W  instruction to IF/ID
inst_valid_o  output  1  inst_o holds the word for pc_i
adel_o  output  1  instruction-address-error flag, qualified by inst_valid_o
bus_req_o  output  1  read request to instruction memory
bus_addr_o  output  ADDR_W  read address, registered
bus_ack_i  input  1  memory ack; bus_rdata_i is valid in the same cycle
bus_rdata_i  input  DATA_W  read data

Behaviour:
- Reset (async): state=IDLE; bus_req_o=0; bus_addr_o=0; inst buffer=NOP_INST; adel_o=0; inst_valid_o=0.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - stallreq_o=ce_i&~flush_i; inst_o=NOP_INST; inst_valid_o=0.
  - ce_i=1, flush_i=0, pc_i[1:0]==0: latch bus_addr_o<=pc_i, bus_req_o<=1, go to BUSY.
  - ce_i=1, flush_i=0, pc_i[1:0]!=0: no bus access; buffer<=NOP_INST, adel<=1, go to DONE.
  - ce_i=0 or flush_i=1: stay in IDLE.
- BUSY:
  - bus_req_o=1 and bus_addr_o stays stable until ack; stallreq_o=1; inst_valid_o=0.
  - bus_ack_i=1, flush_i=0: buffer<=bus_rdata_i, adel<=0, bus_req_o<=0, go to DONE.
  - flush_i=1 with no ack: go to ABORT. The request cannot be withdrawn.
  - flush_i=1 with ack in the same cycle: data discarded, bus_req_o<=0, go to IDLE.
- ABORT:
  - bus_req_o=1, stallreq_o=1, inst_o=NOP_INST.
  - On bus_ack_i: data discarded, bus_req_o<=0, go to IDLE. A flush seen here is ignored.
- DONE:
  - inst_o=buffer; inst_valid_o=1; adel_o valid; stallreq_o=0.
  - flush_i=1: go to IDLE.
  - stall_i[0]=0: the PC advances at this edge; go to IDLE.
  - stall_i[0]=1: hold DONE, with inst_o and adel_o stable for as many cycles as the stall lasts.
- Outside DONE, inst_o=NOP_INST and adel_o=0.
- Latency:
  - Zero-wait memory (ack in the first BUSY cycle) gives 3 cycles per instruction: IDLE, BUSY, DONE.
  - Each memory wait cycle adds 1.
- Exactly one bus read per accepted PC. Bus requests are never issued back-to-back without an IDLE cycle between them.
- Bus rule: once bus_req_o rises it stays high with a constant address until the cycle bus_ack_i=1. bus_ack_i is ignored while bus_req_o=0.
- rst mid-transaction: bus_req_o drops asynchronously. The memory must tolerate an abandoned request after reset.

Test Plan:
- Reset released, PC at 32'h0000_3000, memory acks with 0 wait, rdata=32'h2401_0005 -> bus_req_o high one cycle at addr 32'h0000_3000; inst_o=32'h2401_0005 with inst_valid_o=1 in cycle 3; stallreq_o=1 for cycles 1-2 and 0 in cycle 3.
- Memory acks after 3 wait cycles -> bus_req_o and bus_addr_o stay stable for 4 cycles; stallreq_o stays 1 until DONE; exactly one ack is consumed.
- flush_i pulsed in the second BUSY cycle, ack arrives 2 cycles later with 32'hDEAD_BEEF -> ABORT; inst_valid_o stays 0; 32'hDEAD_BEEF never appears on inst_o; the next fetch uses the new PC.
- DONE reached with stall_i[0]=1 held for 4 cycles -> inst_o stays constant, no new bus_req_o, stallreq_o=0; IDLE is entered on the edge where stall_i[0] falls.
- pc_i=32'h0000_3002 -> no bus_req_o; DONE with inst_o=NOP_INST, adel_o=1, inst_valid_o=1.
- rst asserted while in BUSY -> bus_req_o=0 immediately; all outputs at reset values; ce_i=0 keeps the block in IDLE with stallreq_o=0.
